uart_tx_fifo_sched: RTL
=======================

Name: uart_tx_fifo_sched

Overview:
- Transmit-side scheduler that drains the UART TX byte FIFO into the UART transmitter core.
- FIFO is instantiated in word-read mode: each read yields 4 bytes and advances the read pointer by 4.
- Software programs a byte count and pulses start. The block fetches words only when enough data is present, then serialises bytes LSB-first to the TX core over a valid/ready handshake.
- On completion or abort, it resets the FIFO read pointer and signals done.

Parameters:
- AWIDTH, 8, FIFO address width; pointers and lengths are AWIDTH+1 bits wide.
- TIMEOUT_CYC, 4096, stall limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle pulse that starts a transfer of len_i bytes.
- len_i  in  AWIDTH+1  bytes to send, sampled on an accepted start.
- abort_i  in  1  terminates the transfer at the next edge.
- fifo_wptr_i  in  AWIDTH+1  FIFO write pointer (byte count written).
- fifo_rptr_i  in  AWIDTH+1  FIFO read pointer.
- fifo_rdata_i  in  32  FIFO read word, combinationally valid while fifo_re_o=1.
- fifo_re_o  out  1  FIFO read strobe, one cycle per word.
- fifo_rptr_rst_o  out  1  one-cycle pulse that resets the FIFO read pointer.
- tx_data_o  out  8  byte to the TX core.
- tx_valid_o  out  1  tx_data_o is valid.
- tx_ready_i  in  1  TX core accepts the byte this cycle.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- sent_cnt_o  out  AWIDTH+1  bytes accepted by the TX core in the current or last transfer.
- timeout_o  out  1  sticky stall flag; tied 0 without the optional feature.

Behaviour:
- Reset (rst_i=1 at an edge):
  - State=IDLE; all outputs 0, tx_data_o=0, sent_cnt_o=0.
  - The internal word register, remaining count and byte index are cleared.
- Derived availability:
  - avail = fifo_wptr_i - fifo_rptr_i when fifo_wptr_i >= fifo_rptr_i, else 0. Never negative.
  - need = min(4, remaining).
- IDLE:
  - busy_o=0.
  - On start_i: remaining=len_i clamped to 2^AWIDTH; sent_cnt_o=0.
  - If len_i=0, go to DONE; otherwise go to FETCH.
- FETCH:
  - busy_o=1.
  - When avail >= need: assert fifo_re_o for exactly one cycle, capture fifo_rdata_i into the word register in that same cycle, set byte index=0, go to SEND.
  - Otherwise wait; fifo_re_o stays 0.
- SEND:
  - tx_data_o = word register byte[idx], with idx 0 being bits 7:0; tx_valid_o=1.
  - tx_data_o must stay stable until accepted.
  - On tx_valid_o & tx_ready_i: remaining-1, sent_cnt_o+1, idx+1.
    - If remaining becomes 0, go to DONE.
    - Else if idx was 3, go to FETCH.
    - Else stay in SEND with the next byte, driving valid back-to-back with no bubble.
  - Throughput: 1 byte/cycle within a word; 1 idle cycle per word boundary (the FETCH cycle).
- DONE:
  - done_o=1 and fifo_rptr_rst_o=1 for one cycle; busy_o=0; go to IDLE.
  - sent_cnt_o holds its value until the next accepted start.
- Abort:
  - abort_i in FETCH or SEND takes the next edge to DONE.
  - tx_valid_o drops that cycle; no further fifo_re_o is issued.
  - sent_cnt_o reflects only bytes already accepted.
  - abort_i in IDLE is ignored.
- Priority: rst_i > abort_i > start_i.
  - start_i while busy is ignored.
  - start_i and abort_i in the same IDLE cycle: start wins.
- A partial final word is permitted: leftover bytes in the last fetched word are discarded.

Optional Feature:
- UART_TX_SCHED_TIMEOUT_EN defined:
  - A stall counter increments each cycle spent in FETCH with avail < need, or in SEND with tx_ready_i=0.
  - The counter clears on any fifo_re_o or tx accept.
  - When it reaches TIMEOUT_CYC, timeout_o is set and the FSM behaves as if aborted (goes to DONE).
  - timeout_o clears on the next accepted start_i or on rst_i.
- Not defined:
  - No counter logic; timeout_o is constant 0; stalls wait forever.

Test Plan:
1. wptr=8, rptr=0, len=8, tx_ready=1 -> two fifo_re_o pulses. Bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 from words 0x44332211 and 0x88776655. done_o one cycle after the 8th accept; sent_cnt_o=8; fifo_rptr_rst_o pulses with done_o.
2. len=6, data available -> two reads; 6 bytes sent; bytes 2-3 of the second word are dropped; sent_cnt_o=6.
3. len=4, wptr=rptr=0, then wptr=4 after 20 cycles -> fifo_re_o=0 while waiting; a read fires in the cycle wptr becomes 4; 4 bytes follow.
4. tx_ready_i toggled 1,0,0,1 -> tx_data_o and tx_valid_o held through the stalls; no byte duplicated or skipped.
5. Abort after 3 accepts of len=10 -> tx_valid_o=0 next cycle; done_o pulse; sent_cnt_o=3; start_i issued during busy is ignored.
6. With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, tx_ready_i held 0 -> timeout_o=1 after 16 stall cycles; done_o pulses; the next start_i clears timeout_o.

Source files
------------

// File: rtl/uart_tx_fifo_sched_if.sv
// Handshake bundle between the TX FIFO scheduler, the word-read FIFO and the UART TX core.
// slave is the scheduler's view; master is the view of whatever drives it.
interface uart_tx_fifo_sched_if #(
    parameter int AWIDTH = 8
);
    logic              start_i;
    logic [AWIDTH:0]   len_i;
    logic              abort_i;
    logic [AWIDTH:0]   fifo_wptr_i;
    logic [AWIDTH:0]   fifo_rptr_i;
    logic [31:0]       fifo_rdata_i;
    logic              fifo_re_o;
    logic              fifo_rptr_rst_o;
    logic [7:0]        tx_data_o;
    logic              tx_valid_o;
    logic              tx_ready_i;
    logic              busy_o;
    logic              done_o;
    logic [AWIDTH:0]   sent_cnt_o;
    logic              timeout_o;

    modport slave (
        input  start_i, len_i, abort_i, fifo_wptr_i, fifo_rptr_i, fifo_rdata_i, tx_ready_i,
        output fifo_re_o, fifo_rptr_rst_o, tx_data_o, tx_valid_o, busy_o, done_o,
               sent_cnt_o, timeout_o
    );

    modport master (
        output start_i, len_i, abort_i, fifo_wptr_i, fifo_rptr_i, fifo_rdata_i, tx_ready_i,
        input  fifo_re_o, fifo_rptr_rst_o, tx_data_o, tx_valid_o, busy_o, done_o,
               sent_cnt_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_fifo_sched.sv
// Drains a word-read TX FIFO into the UART TX core one byte at a time, LSB byte first.
// Define UART_TX_SCHED_TIMEOUT_EN to add the stall timeout (limit TIMEOUT_CYC cycles).
module uart_tx_fifo_sched #(
    parameter int AWIDTH      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    uart_tx_fifo_sched_if.slave  bus
);
    localparam int PW = AWIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;

    state_e        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [PW-1:0] rem_q, rem_d;
    logic [PW-1:0] sent_q, sent_d;
    logic [1:0]    idx_q, idx_d;
    logic [PW-1:0] avail, need;
    logic          start_acc, timeout_hit, abort_eff;

    // A read pointer ahead of the write pointer means nothing usable, never a wrap.
    assign avail     = (bus.fifo_wptr_i >= bus.fifo_rptr_i) ? bus.fifo_wptr_i - bus.fifo_rptr_i : '0;
    assign need      = (rem_q >= PW'(4)) ? PW'(4) : rem_q;
    assign start_acc = (state_q == IDLE) && bus.start_i;
    assign abort_eff = bus.abort_i || timeout_hit;

    assign bus.tx_data_o  = word_q[{idx_q, 3'b000} +: 8];
    assign bus.sent_cnt_o = sent_q;

    always_comb begin
        // NOTE: every next-state value and output gets a default first, so no path can infer a latch.
        state_d             = state_q;
        word_d              = word_q;
        rem_d               = rem_q;
        idx_d               = idx_q;
        sent_d              = sent_q;
        bus.fifo_re_o       = 1'b0;
        bus.fifo_rptr_rst_o = 1'b0;
        bus.tx_valid_o      = 1'b0;
        bus.busy_o          = 1'b0;
        bus.done_o          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    sent_d  = '0;
                    rem_d   = bus.len_i[AWIDTH] ? (PW'(1) << AWIDTH) : bus.len_i;
                    state_d = (bus.len_i == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                bus.busy_o = 1'b1;
                if (abort_eff) begin
                    state_d = DONE;
                end else if (avail >= need) begin
                    bus.fifo_re_o = 1'b1;
                    word_d        = bus.fifo_rdata_i;
                    idx_d         = 2'd0;
                    state_d       = SEND;
                end
            end
            SEND: begin
                bus.busy_o = 1'b1;
                // Valid drops in the abort cycle so no byte is accepted behind the abort.
                bus.tx_valid_o = !bus.abort_i;
                if (abort_eff) begin
                    state_d = DONE;
                end else if (bus.tx_ready_i) begin
                    rem_d  = rem_q - PW'(1);
                    sent_d = sent_q + PW'(1);
                    idx_d  = idx_q + 2'd1;
                    if (rem_q == PW'(1)) begin
                        state_d = DONE;
                    end else if (idx_q == 2'd3) begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                bus.done_o          = 1'b1;
                bus.fifo_rptr_rst_o = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            sent_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            word_q  <= word_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            sent_q  <= sent_d;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);

    logic [SW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;
    logic          stalling;

    // Any progress (word read or byte accept) or leaving FETCH/SEND restarts the count.
    always_comb begin
        stalling    = ((state_q == FETCH) && (avail < need)) ||
                      ((state_q == SEND) && !bus.tx_ready_i);
        stall_d     = stalling ? stall_q + SW'(1) : '0;
        timeout_hit = stalling && (stall_q == SW'(TIMEOUT_CYC - 1));
        timeout_d   = timeout_q;
        if (start_acc) timeout_d = 1'b0;
        if (timeout_hit) timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

endmodule
